// File: rtl/alu_seq_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: op codes, compare modes
// and sequencer states, plus the compare-mode decode used when ALU_SEQ_CMP_EN is defined.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    CMP_LT = 3'b000,
    CMP_GT = 3'b001,
    CMP_LE = 3'b010,
    CMP_GE = 3'b011,
    CMP_NE = 3'b100,
    CMP_EQ = 3'b110
  } cmp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Undefined compare codes produce 0.
  function automatic logic cmp_decode(input logic [2:0] cmp, input logic lt, input logic eq);
    logic set;
    case (cmp)
      CMP_LT:  set = lt;
      CMP_GT:  set = ~(lt | eq);
      CMP_LE:  set = lt | eq;
      CMP_GE:  set = ~lt;
      CMP_EQ:  set = eq;
      CMP_NE:  set = ~eq;
      default: set = 1'b0;
    endcase
    return set;
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/result bundle between decode/writeback (master) and the serial ALU sequencer (slave).
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [2:0]       cmp_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  modport master (
    output start_i, ctrl_i, cmp_i, src1_i, src2_i,
    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );

  modport slave (
    input  start_i, ctrl_i, cmp_i, src1_i, src2_i,
    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );
endinterface

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, AND/OR/ADD/SLT.
// Carry-out is only meaningful for the adder ops; AND/OR force it low.
module alu_bit_slice
  import alu_seq_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic less,
  input  logic a_inv,
  input  logic b_inv,
  input  op_e  op,
  output logic result,
  output logic cout
);

  logic aa;
  logic bb;
  logic sum;
  logic carry;

  assign aa    = a ^ a_inv;
  assign bb    = b ^ b_inv;
  assign sum   = aa ^ bb ^ cin;
  assign carry = (aa & bb) | (cin & (aa ^ bb));

  always_comb begin
    result = 1'b0;
    cout   = 1'b0;
    case (op)
      OP_AND: result = aa & bb;
      OP_OR:  result = aa | bb;
      OP_ADD: begin
        result = sum;
        cout   = carry;
      end
      OP_SLT: begin
        result = less;
        cout   = carry;
      end
      default: begin
        result = 1'b0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one slice stepped LSB-first over WIDTH cycles, then FIX and DONE.
// Define ALU_SEQ_CMP_EN to enable the cmp_i compare-mode decode for SLT; otherwise set = lt.
module alu_serial_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk_i,
  input logic rst_i,
  alu_serial_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] final_res;
  logic [3:0]       ctrl;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             set_bit;
  logic             cout_msb;
  logic             ovf_msb;
  logic             a_eff;
  logic             b_eff;
  logic             sum_bit;
  logic             set_calc;
  logic             slice_res;
  logic             slice_cout;
  op_e              op;

  assign op      = op_e'(ctrl[1:0]);
  assign a_eff   = src_a[cnt] ^ ctrl[3];
  assign b_eff   = src_b[cnt] ^ ctrl[2];
  // Raw sum bit is tracked for every op; at the MSB it is the uncorrected sign used as lt.
  assign sum_bit = a_eff ^ b_eff ^ carry;

`ifdef ALU_SEQ_CMP_EN
  logic [2:0] cmp;
  logic       sum_nz;
  logic       eq_calc;

  assign eq_calc  = ~(sum_nz | sum_bit);
  assign set_calc = cmp_decode(cmp, sum_bit, eq_calc);
`else
  logic unused_cmp;

  assign unused_cmp = ^bus.cmp_i;
  assign set_calc   = sum_bit;
`endif

  alu_bit_slice u_slice (
    .a      (src_a[cnt]),
    .b      (src_b[cnt]),
    .cin    (carry),
    .less   (1'b0),
    .a_inv  (ctrl[3]),
    .b_inv  (ctrl[2]),
    .op     (op),
    .result (slice_res),
    .cout   (slice_cout)
  );

  // SLT leaves all slice bits 0; the set flag is patched into bit 0 on the way out.
  assign final_res = (op == OP_SLT) ? {res[WIDTH-1:1], set_bit} : res;

  assign bus.busy_o = (state != IDLE);
  assign bus.done_o = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_a          <= '0;
      src_b          <= '0;
      res            <= '0;
      ctrl           <= '0;
      cnt            <= '0;
      carry          <= 1'b0;
      set_bit        <= 1'b0;
      cout_msb       <= 1'b0;
      ovf_msb        <= 1'b0;
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b0;
      bus.cout_o     <= 1'b0;
      bus.overflow_o <= 1'b0;
`ifdef ALU_SEQ_CMP_EN
      cmp            <= '0;
      sum_nz         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            src_a <= bus.src1_i;
            src_b <= bus.src2_i;
            ctrl  <= bus.ctrl_i;
            carry <= bus.ctrl_i[2];
            cnt   <= '0;
            res   <= '0;
`ifdef ALU_SEQ_CMP_EN
            cmp    <= bus.cmp_i;
            sum_nz <= 1'b0;
`endif
          end
        end
        RUN: begin
          res[cnt] <= slice_res;
          carry    <= slice_cout;
`ifdef ALU_SEQ_CMP_EN
          sum_nz   <= sum_nz | sum_bit;
`endif
          if (cnt == LAST) begin
            set_bit  <= set_calc;
            cout_msb <= slice_cout;
            ovf_msb  <= carry ^ slice_cout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          bus.result_o   <= final_res;
          bus.zero_o     <= (final_res == '0);
          bus.cout_o     <= (op == OP_ADD) & cout_msb;
          bus.overflow_o <= (op == OP_ADD) & ovf_msb;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq (WIDTH=32): directed vector table, hand sequences for
// start-while-busy and mid-run reset, and random ops against an arithmetic model.
module tb_alu_serial_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [2:0]  cmp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: whole-word arithmetic on the (optionally inverted) operands.
  function automatic res_t model(input logic [3:0] ctrl, input logic [2:0] cmp,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa, bb;
    logic [32:0] s;
    logic        lt, eq, set;
    res_t        r;
    aa  = ctrl[3] ? ~a : a;
    bb  = ctrl[2] ? ~b : b;
    s   = {1'b0, aa} + {1'b0, bb} + {32'd0, ctrl[2]};
    lt  = s[31];
    eq  = (s[31:0] == 32'd0);
    set = lt;
`ifdef ALU_SEQ_CMP_EN
    case (cmp)
      3'b000:  set = lt;
      3'b001:  set = !(lt || eq);
      3'b010:  set = lt || eq;
      3'b011:  set = !lt;
      3'b110:  set = eq;
      3'b100:  set = !eq;
      default: set = 1'b0;
    endcase
`else
    if (cmp == 3'b111 && eq) set = lt;
`endif
    r = '0;
    case (ctrl[1:0])
      2'b00: r.result = aa & bb;
      2'b01: r.result = aa | bb;
      2'b10: begin
        r.result = s[31:0];
        r.cout   = s[32];
        r.ovf    = (aa[31] == bb[31]) && (s[31] != aa[31]);
      end
      default: r.result = {31'd0, set};
    endcase
    r.zero = (r.result == 32'd0);
    return r;
  endfunction

  // Issue one op from IDLE, scramble inputs after accept, wait for done and check everything.
  task automatic do_op(input string name, input logic [3:0] ctrl, input logic [2:0] cmp,
                       input logic [31:0] a, input logic [31:0] b, input res_t exp);
    int lat;
    @(negedge clk);
    bus.ctrl_i  = ctrl;
    bus.cmp_i   = cmp;
    bus.src1_i  = a;
    bus.src2_i  = b;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    bus.ctrl_i  = 4'($urandom);
    bus.cmp_i   = 3'($urandom);
    lat = 1;
    while (!bus.done_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, W + 2);
    check({name, "_busy"}, bus.busy_o, 1'b1);
    check({name, "_result"}, bus.result_o, exp.result);
    check({name, "_flags"}, {bus.zero_o, bus.cout_o, bus.overflow_o}, {exp.zero, exp.cout, exp.ovf});
    @(negedge clk);
    check({name, "_done_pulse"}, {bus.done_o, bus.busy_o}, 2'b00);
    check({name, "_held"}, bus.result_o, exp.result);
  endtask

  vec_t vecs[$];

  initial begin
    int   cyc;
    int   gap;
    int   dones;
    logic went_idle;
    res_t exp;

    bus.start_i = 1'b0;
    bus.ctrl_i  = '0;
    bus.cmp_i   = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;

    vecs.push_back('{4'b0010, 3'b000, 32'd5,        32'd3,        32'd8,          1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0110, 3'b000, 32'd3,        32'd5,        32'hFFFFFFFE,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0110, 3'b000, 32'd7,        32'd7,        32'd0,          1'b1, 1'b1, 1'b0});
    vecs.push_back('{4'b0010, 3'b000, 32'h7FFFFFFF, 32'd1,        32'h80000000,   1'b0, 1'b0, 1'b1});
    vecs.push_back('{4'b0010, 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,          1'b1, 1'b1, 1'b0});
    vecs.push_back('{4'b0111, 3'b000, 32'd3,        32'd5,        32'd1,          1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0111, 3'b000, 32'd5,        32'd3,        32'd0,          1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 3'b000, 32'h0000000F, 32'h000000F0, 32'h000000FF,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b1100, 3'b000, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000,   1'b0, 1'b0, 1'b0});
`ifdef ALU_SEQ_CMP_EN
    vecs.push_back('{4'b0111, 3'b011, 32'd7,        32'd7,        32'd1,          1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0111, 3'b100, 32'd7,        32'd7,        32'd0,          1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'b0111, 3'b110, 32'd9,        32'd9,        32'd1,          1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'b0111, 3'b001, 32'd9,        32'd2,        32'd1,          1'b0, 1'b0, 1'b0});
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {bus.busy_o, bus.done_o}, 2'b00);
    check("reset_data", {bus.result_o, bus.zero_o, bus.cout_o, bus.overflow_o}, 35'd0);

    foreach (vecs[i]) begin
      exp = '{vecs[i].result, vecs[i].zero, vecs[i].cout, vecs[i].ovf};
      do_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].cmp, vecs[i].a, vecs[i].b, exp);
    end

    // start_i held high through a run while operands change.
    @(negedge clk);
    bus.ctrl_i  = 4'b0010;
    bus.src1_i  = 32'd5;
    bus.src2_i  = 32'd3;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.src1_i = 32'd10;
    bus.src2_i = 32'd20;
    cyc = 1;
    while (!bus.done_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("held_first_latency", cyc, W + 2);
    check("held_first_result", bus.result_o, 32'd8);
    gap = 0;
    went_idle = 1'b0;
    dones = 0;
    while (gap < 200) begin
      @(negedge clk);
      gap++;
      if (bus.done_o) begin
        dones++;
        break;
      end
      if (!bus.busy_o) went_idle = 1'b1;
      if (went_idle && bus.busy_o) bus.start_i = 1'b0;
    end
    check("held_second_gap", gap, W + 3);
    check("held_second_done", dones, 1);
    check("held_second_result", bus.result_o, 32'd30);
    repeat (5) @(negedge clk);
    check("held_no_third", {bus.busy_o, bus.done_o}, 2'b00);

    // Reset ten cycles into a run aborts it.
    @(negedge clk);
    bus.ctrl_i  = 4'b0010;
    bus.src1_i  = 32'h12345678;
    bus.src2_i  = 32'd1;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", bus.busy_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctrl", {bus.busy_o, bus.done_o}, 2'b00);
    check("abort_result", bus.result_o, 32'd0);
    dones = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) dones++;
    end
    check("abort_no_done", dones, 0);
    do_op("after_abort", 4'b0010, 3'b000, 32'd100, 32'd23, model(4'b0010, 3'b000, 32'd100, 32'd23));

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  c;
      logic [2:0]  m;
      logic [31:0] a, b;
      c = 4'($urandom);
      m = 3'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_op($sformatf("rnd%0d", i), c, m, a, b, model(c, m, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
